decode_stage: RTL
=================

# decode_stage

Parametrised, registered multi-lane RV32I decode stage between the fetch queue and rename. Each cycle it accepts a bundle of `DECODE_WIDTH` fetched instructions, decodes all lanes in parallel, and presents a registered bundle of `instruction_t` to rename. A two-entry skid buffer gives full throughput with a registered `in_ready`. Flush discards all buffered bundles in one cycle.

## Interface
- `DECODE_WIDTH`, default 2: lanes per bundle, 1..4.
- `ADDR_WIDTH`, default 32: instruction address width.
- `DATA_WIDTH`, default 32: instruction word width; fixed at 32 for RV32I.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  pipeline flush from commit/branch recovery.
- `in_valid`  in  1  fetch bundle valid.
- `in_ready`  out  1  stage can accept a bundle.
- `in_bundle`  in  `DECODE_WIDTH` x `fetch_t`  fetched lanes (addr, data, per-lane valid).
- `out_valid`  out  1  decoded bundle valid.
- `out_ready`  in  1  rename accepts the bundle.
- `out_bundle`  out  `DECODE_WIDTH` x `instruction_t`  decoded lanes.
- `out_illegal`  out  `DECODE_WIDTH`  per-lane illegal-instruction flag.

## Operation
- Handshake: transfer on `valid && ready` at each port. `out_valid` must not drop and `out_bundle` must not change while `out_ready` is low.
- Buffer states:
  - EMPTY: nothing held.
  - ONE: main register holds a bundle.
  - TWO: main and skid registers both hold bundles.
- State transitions:
  - EMPTY→ONE on input accept.
  - ONE→TWO on accept without drain.
  - ONE→EMPTY on drain without accept.
  - ONE stays ONE on simultaneous accept and drain.
  - TWO→ONE on drain; skid moves to main.
- `in_ready` = state != TWO, registered.
- Per-lane decode, combinational, ahead of the registers:
  - `addr` and `valid` pass through from `fetch_t`.
  - `opcode` = data[6:0].
  - LOAD, OP_IMM, JALR: I-type immediate, sign-extended; rs1, funct3 and rd from the word.
  - STORE: S-type immediate; rs1, rs2, funct3.
  - OP: rs1, rs2, rd, funct3, funct7; immediate = 0.
  - LUI, AUIPC: immediate = data[31:12]<<12; rd.
  - JAL: J-type immediate; rd.
  - BRANCH: B-type immediate; rs1, rs2, funct3.
  - SYSTEM: immediate = zero-extended data[31:20]; rs1, funct3, rd from the word.
  - Unknown opcode: all fields except addr/opcode/valid = 0.
  - Unused fields are always 0, never X.
- Lane with `valid`=0: all decoded fields zeroed, `out_illegal`=0.
- `flush`: state→EMPTY next edge, and any same-cycle input is dropped. `out_valid`=0 the cycle after flush. Flush has priority over all handshakes.
- Reset mid-operation: immediate return to EMPTY with all outputs at reset values.

## Timing
- Latency: 1 cycle from input accept to `out_valid`.
- Throughput: 1 bundle/cycle while `out_ready`=1.
- Reset values:
  - `in_ready`=1, `out_valid`=0.
  - `out_bundle` all zero.
  - `out_illegal`=0.
- `in_ready` is 1 in the cycle after reset release.
- After flush: `in_ready`=1, and a bundle presented in the following cycle is accepted normally.
- Back-pressure: with `out_ready` held low, exactly two bundles are accepted, then `in_ready`=0 starting the cycle after the second accept.

## Configuration
- `DECODE_ILLEGAL_CHECK_EN` defined: `out_illegal[i]`=1 for a valid lane with any of:
  - unknown opcode;
  - data[1:0]!=2'b11;
  - OP funct7 not 0x00/0x20, or 0x20 with funct3 other than ADD/SRL;
  - OP_IMM shift funct7 illegal;
  - BRANCH funct3 2/3;
  - LOAD funct3 3/6/7;
  - STORE funct3 >2.
- Undefined: `out_illegal` tied to 0. Decode is otherwise identical.

## Structure
- `fetch_t` and `instruction_t` stay in `typedef_pkg`.
- Opcode constants (LOAD … SYSTEM) and the funct3/funct7 legality constants go in `instruction_pkg`.
- Bundle array types `fetch_bundle_t` and `decode_bundle_t`, parametrised by `DECODE_WIDTH`, are declared in `typedef_pkg`.
- One natural sub-module: `rv32_lane_decode`, the combinational single-lane decoder plus illegal check, instantiated `DECODE_WIDTH` times via generate.
- The skid buffer FSM lives in `decode_stage`.

## Test plan
- Reset and ADDI:
  - Stimulus: reset, then lane0 = ADDI x1,x0,-1 (0xFFF00093) at 0x1000.
  - Required next cycle: `out_valid`=1, immediate=0xFFFFFFFF, rd=1, rs1=0, `out_illegal`=0.
- Immediate formats:
  - JAL 0x0080006F gives immediate=8.
  - BEQ 0xFE000EE3 gives immediate=-4 (0xFFFFFFFC).
  - SW 0x00112623 gives immediate=12, rs1=2, rs2=1.
- Back-pressure: hold `out_ready`=0 and stream bundles.
  - Exactly 2 accepted, then `in_ready`=0.
  - Raise `out_ready`: bundles emerge in order with no loss or duplication.
- Flush in TWO: `flush`=1 together with `in_valid`=1.
  - Next cycle `out_valid`=0, `in_ready`=1.
  - The flushed-cycle bundle never appears.
- Illegal lanes: lane1 = 0x00000000, lane0 = ADD.
  - With the macro: `out_illegal`=2'b10.
  - Without the macro: 2'b00.
  - An invalid lane always gives 0.
- Async reset mid-stream: assert `rst_n`=0 between edges.
  - `out_valid`=0 immediately.
  - After release, state is EMPTY and `in_ready`=1.

Source files
------------

// File: rtl/instruction_pkg.sv
// RV32I major opcodes and the funct3/funct7 encodings used by the illegal-instruction check.
package instruction_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_BR_RSV0 = 3'b010;
  localparam logic [2:0] F3_BR_RSV1 = 3'b011;
  localparam logic [2:0] F3_LD_RSV0 = 3'b011;
  localparam logic [2:0] F3_LD_RSV1 = 3'b110;
  localparam logic [2:0] F3_LD_RSV2 = 3'b111;
  localparam logic [2:0] F3_SW      = 3'b010;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // Register-register ALU: the alternate funct7 only selects SUB and SRA.
  function automatic logic op_funct_legal(input logic [2:0] f3, input logic [6:0] f7);
    return (f7 == F7_BASE) ||
           ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA)));
  endfunction

  function automatic logic op_imm_shift_legal(input logic [2:0] f3, input logic [6:0] f7);
    logic ok;
    ok = 1'b1;
    if (f3 == F3_SLL)     ok = (f7 == F7_BASE);
    if (f3 == F3_SRL_SRA) ok = (f7 == F7_BASE) || (f7 == F7_ALT);
    return ok;
  endfunction

endpackage

// File: rtl/typedef_pkg.sv
// Shared pipeline types for the RV32I front end: fetch lanes, decoded lanes and bundle arrays.
package typedef_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned ILEN             = 32;
  localparam int unsigned DECODE_WIDTH_DEF = 2;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [ILEN-1:0] data;
    logic            valid;
  } fetch_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            valid;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
  } instruction_t;

  // Bundles at the default width; other widths use fetch_t/instruction_t [W-1:0] directly.
  typedef fetch_t       [DECODE_WIDTH_DEF-1:0] fetch_bundle_t;
  typedef instruction_t [DECODE_WIDTH_DEF-1:0] decode_bundle_t;

endpackage

// File: rtl/rv32_lane_decode.sv
// Combinational single-lane RV32I decoder with optional illegal-instruction flag.
// Optional feature: DECODE_ILLEGAL_CHECK_EN enables illegal_o; otherwise it is tied low.
module rv32_lane_decode
  import typedef_pkg::*;
  import instruction_pkg::*;
(
  input  fetch_t       fetch_i,
  output instruction_t instr_o,
  output logic         illegal_o
);

  logic [ILEN-1:0] word;
  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_z;

  assign word   = fetch_i.data;
  assign opcode = word[6:0];
  assign rd     = word[11:7];
  assign funct3 = word[14:12];
  assign rs1    = word[19:15];
  assign rs2    = word[24:20];
  assign funct7 = word[31:25];

  assign imm_i = {{20{word[31]}}, word[31:20]};
  assign imm_s = {{20{word[31]}}, word[31:25], word[11:7]};
  assign imm_b = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
  assign imm_u = {word[31:12], 12'b0};
  assign imm_j = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
  assign imm_z = {20'b0, word[31:20]};

  always_comb begin
    instr_o       = '0;
    instr_o.addr  = fetch_i.addr;
    instr_o.valid = fetch_i.valid;
    if (fetch_i.valid) begin
      instr_o.opcode = opcode;
      case (opcode)
        OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
          instr_o.imm    = imm_i;
          instr_o.rs1    = rs1;
          instr_o.funct3 = funct3;
          instr_o.rd     = rd;
        end
        OPC_STORE: begin
          instr_o.imm    = imm_s;
          instr_o.rs1    = rs1;
          instr_o.rs2    = rs2;
          instr_o.funct3 = funct3;
        end
        OPC_OP: begin
          instr_o.rs1    = rs1;
          instr_o.rs2    = rs2;
          instr_o.rd     = rd;
          instr_o.funct3 = funct3;
          instr_o.funct7 = funct7;
        end
        OPC_LUI, OPC_AUIPC: begin
          instr_o.imm = imm_u;
          instr_o.rd  = rd;
        end
        OPC_JAL: begin
          instr_o.imm = imm_j;
          instr_o.rd  = rd;
        end
        OPC_BRANCH: begin
          instr_o.imm    = imm_b;
          instr_o.rs1    = rs1;
          instr_o.rs2    = rs2;
          instr_o.funct3 = funct3;
        end
        OPC_SYSTEM: begin
          instr_o.imm    = imm_z;
          instr_o.rs1    = rs1;
          instr_o.funct3 = funct3;
          instr_o.rd     = rd;
        end
        default: ;
      endcase
    end
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic bad_fields;

  always_comb begin
    bad_fields = 1'b0;
    case (opcode)
      OPC_OP:     bad_fields = !op_funct_legal(funct3, funct7);
      OPC_OP_IMM: bad_fields = !op_imm_shift_legal(funct3, funct7);
      OPC_BRANCH: bad_fields = (funct3 == F3_BR_RSV0) || (funct3 == F3_BR_RSV1);
      OPC_LOAD:   bad_fields = (funct3 == F3_LD_RSV0) || (funct3 == F3_LD_RSV1) ||
                               (funct3 == F3_LD_RSV2);
      OPC_STORE:  bad_fields = (funct3 > F3_SW);
      OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM: bad_fields = 1'b0;
      default:    bad_fields = 1'b1;
    endcase
  end

  assign illegal_o = fetch_i.valid && (bad_fields || (word[1:0] != 2'b11));
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/decode_stage.sv
// Registered multi-lane RV32I decode stage with a two-entry skid buffer between fetch and rename.
// Optional feature: DECODE_ILLEGAL_CHECK_EN enables per-lane illegal-instruction flags.
module decode_stage
  import typedef_pkg::*;
#(
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  fetch_t       [DECODE_WIDTH-1:0]  in_bundle,
  output logic                             out_valid,
  input  logic                             out_ready,
  output instruction_t [DECODE_WIDTH-1:0]  out_bundle,
  output logic         [DECODE_WIDTH-1:0]  out_illegal
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  if ((ADDR_WIDTH != XLEN) || (DATA_WIDTH != ILEN) ||
      (DECODE_WIDTH < 1) || (DECODE_WIDTH > 4)) begin : g_cfg_check
    $error("decode_stage: unsupported DECODE_WIDTH/ADDR_WIDTH/DATA_WIDTH");
  end

  instruction_t [DECODE_WIDTH-1:0] dec_bundle;
  logic         [DECODE_WIDTH-1:0] dec_illegal;

  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_lane
    rv32_lane_decode u_lane (
      .fetch_i   (in_bundle[g]),
      .instr_o   (dec_bundle[g]),
      .illegal_o (dec_illegal[g])
    );
  end

  logic [1:0]                      state_q, state_d;
  logic                            in_ready_q, in_ready_d;
  instruction_t [DECODE_WIDTH-1:0] main_q, main_d;
  instruction_t [DECODE_WIDTH-1:0] skid_q, skid_d;
  logic         [DECODE_WIDTH-1:0] main_ill_q, main_ill_d;
  logic         [DECODE_WIDTH-1:0] skid_ill_q, skid_ill_d;
  logic                            accept;
  logic                            drain;

  assign out_valid   = (state_q != S_EMPTY);
  assign out_bundle  = main_q;
  assign out_illegal = main_ill_q;
  assign in_ready    = in_ready_q;

  assign accept = in_valid && in_ready_q;
  assign drain  = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    main_ill_d = main_ill_q;
    skid_d     = skid_q;
    skid_ill_d = skid_ill_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_d     = dec_bundle;
            main_ill_d = dec_illegal;
            state_d    = S_ONE;
          end
        end
        S_ONE: begin
          // Accept with drain refills main directly; accept alone parks the bundle in skid.
          if (accept && drain) begin
            main_d     = dec_bundle;
            main_ill_d = dec_illegal;
          end else if (accept) begin
            skid_d     = dec_bundle;
            skid_ill_d = dec_illegal;
            state_d    = S_TWO;
          end else if (drain) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (drain) begin
            main_d     = skid_q;
            main_ill_d = skid_ill_q;
            state_d    = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    in_ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      main_ill_q <= '0;
      skid_q     <= '0;
      skid_ill_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      main_ill_q <= main_ill_d;
      skid_q     <= skid_d;
      skid_ill_q <= skid_ill_d;
    end
  end

endmodule
